// File: rtl/hilo_muldiv_pkg.sv
// Shared op codes, FSM state encoding and small op-decode helpers for hilo_muldiv.
package hilo_muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Divide ops have the top op bit set.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Signed ops (MULT, DIV) have the low op bit clear.
    function automatic logic op_is_signed(input logic [1:0] op);
        return !op[0];
    endfunction

endpackage

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, feeding the HI/LO write port.
//
// Handshake: a request is taken on the rising edge that ends a cycle in which
// start=1, cancel=0 and the unit is IDLE. busy is high combinationally in that
// request cycle and stays high through the DONE cycle. hi_we/lo_we pulse
// together for exactly that DONE cycle unless cancel is high in it. start seen
// outside IDLE is dropped, never queued.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    output logic              busy,
    output logic              hi_we,
    output logic              lo_we,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int MD_ITER = DATA_W;
    localparam int CNT_W   = $clog2(DATA_W) + 1;

    md_state_t             state;
    md_state_t             state_nxt;
    logic                  div_q;
    logic                  sign_a;
    logic                  sign_b;
    logic [DATA_W-1:0]     opnd;
    logic [2*DATA_W-1:0]   acc;
    logic [CNT_W-1:0]      cnt;

    logic                  accept;
    logic                  div_zero;
    logic                  last_iter;
    logic [DATA_W-1:0]     a_abs;
    logic [DATA_W-1:0]     b_abs;
    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       prem;
    logic                  q_bit;
    logic [DATA_W-1:0]     rem_sub;
    logic [2*DATA_W-1:0]   acc_nxt;
    logic [2*DATA_W-1:0]   prod_fix;
    logic [DATA_W-1:0]     quo_fix;
    logic [DATA_W-1:0]     rem_fix;
    logic [DATA_W-1:0]     res_hi;
    logic [DATA_W-1:0]     res_lo;

    assign accept    = start && (state == MD_IDLE) && !cancel;
    assign div_zero  = op_is_div(op) && (src_b == '0);
    assign last_iter = (cnt == CNT_W'(MD_ITER - 1));

    // Operand magnitudes: two's-complement absolute value for signed ops only.
    always_comb begin
        a_abs = src_a;
        b_abs = src_b;
        if (op_is_signed(op) && src_a[DATA_W-1]) a_abs = -src_a;
        if (op_is_signed(op) && src_b[DATA_W-1]) b_abs = -src_b;
    end

    // One iteration step of the shared accumulator plus the final sign fixup.
    always_comb begin
        // Multiply: conditionally add the multiplicand to the upper half, shift right.
        mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        // Divide: shift in the next dividend bit, trial-subtract the divisor.
        prem    = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        q_bit   = (prem >= {1'b0, opnd});
        // The difference is below the divisor, so its low bits are exact.
        rem_sub = prem[DATA_W-1:0] - opnd;
        if (div_q)
            acc_nxt = {(q_bit ? rem_sub : prem[DATA_W-1:0]), acc[DATA_W-2:0], q_bit};
        else
            acc_nxt = {mul_sum, acc[DATA_W-1:1]};

        prod_fix = (sign_a ^ sign_b) ? -acc_nxt : acc_nxt;
        quo_fix  = (sign_a ^ sign_b) ? -acc_nxt[DATA_W-1:0] : acc_nxt[DATA_W-1:0];
        rem_fix  = sign_a ? -acc_nxt[2*DATA_W-1:DATA_W] : acc_nxt[2*DATA_W-1:DATA_W];

        if (div_q) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end else begin
            res_hi = prod_fix[2*DATA_W-1:DATA_W];
            res_lo = prod_fix[DATA_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state, stall request and HI/LO write strobes.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        case (state)
            MD_IDLE: begin
                busy = start && !cancel;
                if (accept) state_nxt = div_zero ? MD_DONE : MD_CALC;
            end
            MD_CALC: begin
                busy = 1'b1;
                if (cancel)         state_nxt = MD_IDLE;
                else if (last_iter) state_nxt = MD_DONE;
            end
            MD_DONE: begin
                busy      = 1'b1;
                hi_we     = !cancel;
                lo_we     = !cancel;
                state_nxt = MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    // Operand latch, shared accumulator/counter and registered HI/LO results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        div_q  <= op_is_div(op);
                        sign_a <= op_is_signed(op) && src_a[DATA_W-1];
                        sign_b <= op_is_signed(op) && src_b[DATA_W-1];
                        cnt    <= '0;
                        if (op_is_div(op)) begin
                            acc  <= {{DATA_W{1'b0}}, a_abs};
                            opnd <= b_abs;
                        end else begin
                            acc  <= {{DATA_W{1'b0}}, b_abs};
                            opnd <= a_abs;
                        end
                        // Divide by zero skips CALC and reports dividend / all-ones.
                        if (div_zero) begin
                            hi_o <= src_a;
                            lo_o <= '1;
                        end
                    end
                end
                MD_CALC: begin
                    if (!cancel) begin
                        acc <= acc_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (last_iter) begin
                            hi_o <= res_hi;
                            lo_o <= res_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed, table-driven bench for hilo_muldiv plus hand sequences for cancel/reset/start-in-CALC.
module tb_hilo_muldiv;

    localparam int W   = 32;
    localparam int WIN = 80;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         cancel = 1'b0;
    logic         busy;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int tests  = 0;
    int failed = 0;

    logic [W-1:0] last_hi;
    logic [W-1:0] last_lo;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        string        name;
    } vec_t;

    vec_t vecs[14];

    hilo_muldiv #(.DATA_W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .busy   (busy),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .hi_o   (hi_o),
        .lo_o   (lo_o)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request and watch a fixed window of cycles. Cycle k is the k-th
    // negedge after the request cycle. cancel_at>0 means the op is expected to
    // be squashed; inject_at>0 pulses a second start while the op is running.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input int exp_lat, input int inject_at, input int cancel_at,
                          input bit chk_hold, input string name);
        logic         bsy[0:WIN];
        int           n_strobe;
        int           got_k;
        logic [W-1:0] got_hi;
        logic [W-1:0] got_lo;
        logic         split;
        n_strobe = 0;
        got_k    = -1;
        got_hi   = '0;
        got_lo   = '0;
        split    = 1'b0;
        @(negedge clk);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        #1;
        chk({name, " busy_req"}, 64'(busy), 64'(1));
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            start  = 1'b0;
            cancel = 1'b0;
            if (k == inject_at) begin
                op    = OP_MULT;
                src_a = 32'd3;
                src_b = 32'd3;
                start = 1'b1;
            end
            if (k == cancel_at) cancel = 1'b1;
            #1;
            bsy[k] = busy;
            if (hi_we !== lo_we) split = 1'b1;
            if (hi_we) begin
                if (n_strobe == 0) begin
                    got_k  = k;
                    got_hi = hi_o;
                    got_lo = lo_o;
                end
                n_strobe++;
            end
        end
        cancel = 1'b0;
        chk({name, " we_pair"}, 64'(split), 64'(0));
        if (cancel_at > 0) begin
            chk({name, " strobes"}, 64'(n_strobe), 64'(0));
            chk({name, " busy_after_cancel"}, 64'(bsy[cancel_at+1]), 64'(0));
            if (chk_hold) begin
                chk({name, " hi_hold"}, 64'(hi_o), 64'(exp_hi));
                chk({name, " lo_hold"}, 64'(lo_o), 64'(exp_lo));
            end
        end else begin
            chk({name, " strobes"}, 64'(n_strobe), 64'(1));
            chk({name, " latency"}, 64'(got_k), 64'(exp_lat));
            chk({name, " hi"}, 64'(got_hi), 64'(exp_hi));
            chk({name, " lo"}, 64'(got_lo), 64'(exp_lo));
            chk({name, " busy_done"}, 64'(bsy[exp_lat]), 64'(1));
            chk({name, " busy_after"}, 64'(bsy[exp_lat+1]), 64'(0));
            last_hi = exp_hi;
            last_lo = exp_lo;
        end
    endtask

    initial begin
        int n_strobe;
        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, "multu_max"};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33, "mult_m3x7"};
        vecs[2]  = '{OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFFB, 32'h00000000, 32'h00000019, 33, "mult_m5xm5"};
        vecs[3]  = '{OP_MULT,  32'h7FFFFFFF, 32'd2,        32'h00000000, 32'hFFFFFFFE, 33, "mult_maxpos_x2"};
        vecs[4]  = '{OP_MULTU, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 33, "multu_shift8"};
        vecs[5]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, "mult_minxmin"};
        vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, "div_m7d2"};
        vecs[7]  = '{OP_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 33, "divu_7d2"};
        vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, "div_overflow"};
        vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, "div_7dm2"};
        vecs[10] = '{OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 33, "div_m100dm7"};
        vecs[11] = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33, "divu_100d7"};
        vecs[12] = '{OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1,  "divu_by0"};
        vecs[13] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1,  "div_by0"};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst hi_we", 64'(hi_we), 64'(0));
        chk("rst hi_o", 64'(hi_o), 64'(0));
        chk("rst lo_o", 64'(lo_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        last_hi = '0;
        last_lo = '0;

        // Table of directed operations.
        for (int i = 0; i < 14; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   vecs[i].lat, 0, 0, 1'b0, vecs[i].name);

        // Cancel ten cycles into a DIV: no write, HI/LO keep the previous result.
        run_op(OP_DIV, 32'd100, 32'd7, last_hi, last_lo, 0, 0, 10, 1'b1, "cancel_calc");
        run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 33, 0, 0, 1'b0, "multu_after_cancel");

        // A start pulse during CALC is ignored; the original result is written once.
        run_op(OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 33, 5, 0, 1'b0, "start_in_calc");

        // Cancel in the DONE cycle masks the strobe.
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 0, 0, 33, 1'b0, "cancel_done");

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        op    = OP_MULTU;
        src_a = 32'd6;
        src_b = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid busy", 64'(busy), 64'(0));
        chk("rst_mid hi_we", 64'(hi_we), 64'(0));
        chk("rst_mid hi_o", 64'(hi_o), 64'(0));
        chk("rst_mid lo_o", 64'(lo_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        n_strobe = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (hi_we || lo_we || busy) n_strobe++;
        end
        chk("rst_mid no_activity", 64'(n_strobe), 64'(0));
        chk("rst_mid hi_after", 64'(hi_o), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
